// File: rtl/dmem_responder_pkg.sv
// -----------------------------------------------------------------------------
// dmem_responder_pkg
// Shared definitions for the multicore data-memory responder:
//   - FSM state encoding (IDLE / ACCESS / ACK)
//   - default width constants for the responder parameters
//   - helper that sizes a core-index field
// Configuration macro: DMEM_RR_EN (round-robin arbitration when defined,
// fixed lowest-index priority otherwise); consumed by dmem_responder.
// -----------------------------------------------------------------------------
package dmem_responder_pkg;

    localparam int DMEM_NUM_CORES_DEF = 2;
    localparam int DMEM_ADDR_W_DEF    = 8;
    localparam int DMEM_DATA_W_DEF    = 8;
    localparam int DMEM_DEPTH_DEF     = 256;

    typedef enum logic [1:0] {
        DMEM_IDLE   = 2'd0,
        DMEM_ACCESS = 2'd1,
        DMEM_ACK    = 2'd2
    } dmem_state_e;

    // Width of a core-index field; never narrower than one bit.
    function automatic int dmem_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Combinational winner search over the per-core request vector. The search
// starts at i_ptr and wraps; the first asserted request wins.
// Ports:
//   i_req          in   NUM_CORES  per-core request
//   i_ptr          in   IDX_W      search start index
//   o_grant_valid  out  1          some request is asserted
//   o_grant_idx    out  IDX_W      index of the winning core
// -----------------------------------------------------------------------------
module dmem_arbiter
    import dmem_responder_pkg::*;
#(
    parameter int NUM_CORES = DMEM_NUM_CORES_DEF,
    parameter int IDX_W     = dmem_idx_w(NUM_CORES)
) (
    input  logic [NUM_CORES-1:0] i_req,
    input  logic [IDX_W-1:0]     i_ptr,
    output logic                 o_grant_valid,
    output logic [IDX_W-1:0]     o_grant_idx
);

    // Scan from the farthest offset down to offset 0 so that the request
    // closest to the pointer is the last one written and therefore wins.
    always_comb begin
        // NOTE: every output gets a default before any branch so no path
        // leaves a value held, which would infer a latch.
        o_grant_valid = 1'b0;
        o_grant_idx   = '0;
        for (int k = NUM_CORES - 1; k >= 0; k--) begin
            int j;
            j = int'(i_ptr) + k;
            if (j >= NUM_CORES) j = j - NUM_CORES;
            if (i_req[j]) begin
                o_grant_valid = 1'b1;
                o_grant_idx   = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
// Shared data-memory responder: arbitrates NUM_CORES core data ports onto a
// single register-array memory, one 8-bit read or write per grant, and
// returns a one-cycle acknowledge (plus read data) to the granted core.
// Timing: request seen in IDLE (cycle 0), memory access (cycle 1),
// ack (cycle 2); one access every 3 cycles.
// Configuration macro: DMEM_RR_EN
//   defined   -> round-robin arbitration, pointer advances past each winner
//   undefined -> fixed priority, lowest index wins (no pointer register)
// Ports:
//   CLK    in   1                   system clock, rising edge
//   RST_N  in   1                   asynchronous active-low reset
//   req    in   NUM_CORES           per-core request, held until ack
//   we     in   NUM_CORES           per-core write strobe (1 = write)
//   addr   in   NUM_CORES*ADDR_W    per-core address, core i at [i*ADDR_W +: ADDR_W]
//   wdata  in   NUM_CORES*DATA_W    per-core write data, same slicing
//   ack    out  NUM_CORES           one-hot completion pulse
//   rdata  out  NUM_CORES*DATA_W    per-core read data, held until next read ack
//   busy   out  1                   high in ACCESS and ACK
// -----------------------------------------------------------------------------
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int NUM_CORES = DMEM_NUM_CORES_DEF,
    parameter int ADDR_W    = DMEM_ADDR_W_DEF,
    parameter int DATA_W    = DMEM_DATA_W_DEF,
    parameter int DEPTH     = DMEM_DEPTH_DEF
) (
    input  logic                          CLK,
    input  logic                          RST_N,
    input  logic [NUM_CORES-1:0]          req,
    input  logic [NUM_CORES-1:0]          we,
    input  logic [NUM_CORES*ADDR_W-1:0]   addr,
    input  logic [NUM_CORES*DATA_W-1:0]   wdata,
    output logic [NUM_CORES-1:0]          ack,
    output logic [NUM_CORES*DATA_W-1:0]   rdata,
    output logic                          busy
);

    localparam int IDX_W = dmem_idx_w(NUM_CORES);

    dmem_state_e                 r_state;
    dmem_state_e                 w_state_nxt;

    logic                        w_grant_valid;
    logic [IDX_W-1:0]            w_grant_idx;
    logic [IDX_W-1:0]            w_ptr;

    // Access captured in IDLE; only these copies are used afterwards, so a
    // core dropping or changing its inputs mid-access has no effect.
    logic [IDX_W-1:0]            r_win_idx;
    logic                        r_we;
    logic [ADDR_W-1:0]           r_addr;
    logic [DATA_W-1:0]           r_wdata;

    logic [NUM_CORES*DATA_W-1:0] r_rdata;
    logic [DATA_W-1:0]           r_mem [DEPTH];

    // -------------------------------------------------------------------------
    // Arbitration pointer
    // -------------------------------------------------------------------------
`ifdef DMEM_RR_EN
    logic [IDX_W-1:0] r_ptr;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_ptr <= '0;
        end else if (r_state == DMEM_ACK) begin
            r_ptr <= (r_win_idx == IDX_W'(NUM_CORES - 1)) ? '0 : r_win_idx + 1'b1;
        end
    end

    assign w_ptr = r_ptr;
`else
    assign w_ptr = '0;
`endif

    dmem_arbiter #(
        .NUM_CORES (NUM_CORES),
        .IDX_W     (IDX_W)
    ) u_arbiter (
        .i_req         (req),
        .i_ptr         (w_ptr),
        .o_grant_valid (w_grant_valid),
        .o_grant_idx   (w_grant_idx)
    );

    // -------------------------------------------------------------------------
    // FSM
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST_N) begin
        // NOTE: state elements use non-blocking assignments so every flop
        // samples pre-edge values regardless of block ordering.
        if (!RST_N) r_state <= DMEM_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        ack         = '0;
        busy        = 1'b0;
        unique case (r_state)
            DMEM_IDLE: begin
                if (w_grant_valid) w_state_nxt = DMEM_ACCESS;
            end
            DMEM_ACCESS: begin
                busy        = 1'b1;
                w_state_nxt = DMEM_ACK;
            end
            DMEM_ACK: begin
                busy           = 1'b1;
                ack[r_win_idx] = 1'b1;
                w_state_nxt    = DMEM_IDLE;
            end
            default: w_state_nxt = DMEM_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Request capture
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_win_idx <= '0;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
        end else if (r_state == DMEM_IDLE && w_grant_valid) begin
            r_win_idx <= w_grant_idx;
            r_we      <= we[w_grant_idx];
            r_addr    <= addr[int'(w_grant_idx)*ADDR_W +: ADDR_W];
            r_wdata   <= wdata[int'(w_grant_idx)*DATA_W +: DATA_W];
        end
    end

    // -------------------------------------------------------------------------
    // Memory array and read-data registers
    // -------------------------------------------------------------------------
    // NOTE: the memory array has no reset; contents survive RST_N, and an
    // access abandoned by reset never writes because the state has left
    // ACCESS before the next edge.
    always_ff @(posedge CLK) begin
        if (r_state == DMEM_ACCESS && r_we) r_mem[r_addr] <= r_wdata;
    end

    // The read word lands in the winner's slice on the edge entering ACK, so
    // it is valid alongside the ack pulse and held until that core's next read.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_rdata <= '0;
        end else if (r_state == DMEM_ACCESS && !r_we) begin
            r_rdata[int'(r_win_idx)*DATA_W +: DATA_W] <= r_mem[r_addr];
        end
    end

    assign rdata = r_rdata;

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
// Directed self-checking bench for dmem_responder with two cores.
// Expected values are hand-computed; arbitration expectations follow
// DMEM_RR_EN when it is defined for the build.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_dmem_responder;

    logic        CLK;
    logic        RST_N;
    logic [1:0]  req;
    logic [1:0]  we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [1:0]  ack;
    logic [15:0] rdata;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;

    dmem_responder #(
        .NUM_CORES (2),
        .ADDR_W    (8),
        .DATA_W    (8),
        .DEPTH     (256)
    ) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .req   (req),
        .we    (we),
        .addr  (addr),
        .wdata (wdata),
        .ack   (ack),
        .rdata (rdata),
        .busy  (busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // One complete access from core c; checks 2-cycle latency and one-hot ack.
    task automatic access(input int c, input logic w, input logic [7:0] a,
                          input logic [7:0] d, output logic [7:0] rd);
        int n;
        req[c]            = 1'b1;
        we[c]             = w;
        addr[c*8 +: 8]    = a;
        wdata[c*8 +: 8]   = d;
        n = 0;
        while (!ack[c] && n < 20) begin
            tick();
            n++;
        end
        check($sformatf("latency core%0d", c), n, 2);
        check($sformatf("ack onehot core%0d", c), {30'd0, ack}, 32'(1 << c));
        rd     = rdata[c*8 +: 8];
        req[c] = 1'b0;
        tick();
    endtask

    task automatic do_reset();
        RST_N = 1'b0;
        #1;
        check("reset ack", {30'd0, ack}, 0);
        check("reset busy", {31'd0, busy}, 0);
        check("reset rdata", {16'd0, rdata}, 0);
        tick();
        tick();
        #2 RST_N = 1'b1;
        tick();
    endtask

    initial begin
        logic [7:0] rd;
        int g0, g1, both;
        int grants [4];
        int ng, n1;
        int t1, t2, nacks;
        int exp_g [4];

        req = '0; we = '0; addr = '0; wdata = '0;
        RST_N = 1'b1;
        #2;
        do_reset();

        // Single write then read from core0, with core1 holding 0x11 in its slice.
        access(0, 1'b1, 8'h10, 8'h5A, rd);
        check("write leaves rdata", {16'd0, rdata}, 32'h0000);
        access(1, 1'b1, 8'h20, 8'h11, rd);
        access(1, 1'b0, 8'h20, 8'h00, rd);
        check("core1 read 0x20", {24'd0, rd}, 32'h11);
        access(0, 1'b0, 8'h10, 8'h00, rd);
        check("core0 read 0x10", {24'd0, rd}, 32'h5A);
        check("rdata both slices", {16'd0, rdata}, 32'h115A);

        // Busy during ACCESS and ACK.
        req[0] = 1'b1; we[0] = 1'b0; addr[7:0] = 8'h10;
        check("busy idle", {31'd0, busy}, 0);
        tick();
        check("busy access", {31'd0, busy}, 1);
        tick();
        check("busy ack", {31'd0, busy}, 1);
        req[0] = 1'b0;
        tick();
        check("busy back idle", {31'd0, busy}, 0);

        // Cross-core visibility at the top address.
        access(1, 1'b1, 8'hFF, 8'hC3, rd);
        access(0, 1'b0, 8'hFF, 8'h00, rd);
        check("core0 read 0xFF", {24'd0, rd}, 32'hC3);

        // Simultaneous reads from pointer 0; each core drops req at its ack.
        do_reset();
        req = 2'b11; we = 2'b00; addr = {8'hFF, 8'h10};
        g0 = -1; g1 = -1; both = 0;
        for (int cyc = 1; cyc <= 15 && req != 2'b00; cyc++) begin
            tick();
            if (ack == 2'b11) both++;
            if (ack[0]) begin g0 = cyc; req[0] = 1'b0; end
            if (ack[1]) begin g1 = cyc; req[1] = 1'b0; end
        end
        req = 2'b00;
        tick();
        check("simul core0 ack cycle", g0, 2);
        check("simul core1 ack cycle", g1, 5);
        check("simul no double ack", both, 0);
        check("simul rdata", {16'd0, rdata}, 32'hC35A);

        // Continuous requests from both cores.
`ifdef DMEM_RR_EN
        exp_g = '{0, 1, 0, 1};
`else
        exp_g = '{0, 0, 0, 0};
`endif
        req = 2'b11;
        ng = 0; n1 = 0;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            tick();
            if (ack[1]) n1++;
            if (ack != 2'b00 && ng < 4) begin
                grants[ng] = ack[1] ? 1 : 0;
                ng++;
            end
        end
        req = 2'b00;
        tick();
        tick();
        tick();
        check("cont grant count", ng, 4);
        for (int i = 0; i < 4; i++) check($sformatf("cont grant %0d", i), grants[i], exp_g[i]);
`ifdef DMEM_RR_EN
        check("cont core1 acks", n1, 2);
`else
        check("cont core1 acks", n1, 0);
`endif

        // Req held across ack is served again three cycles later.
        req[0] = 1'b1; we[0] = 1'b0; addr[7:0] = 8'h10;
        t1 = -1; t2 = -1; nacks = 0;
        for (int cyc = 1; cyc <= 12 && nacks < 2; cyc++) begin
            tick();
            if (ack[0]) begin
                nacks++;
                if (nacks == 1) t1 = cyc;
                else begin t2 = cyc; req[0] = 1'b0; end
            end
        end
        req[0] = 1'b0;
        tick();
        check("held first ack", t1, 2);
        check("held second ack", t2, 5);
        check("held rdata", {24'd0, rdata[7:0]}, 32'h5A);

        // Reset in ACCESS of a write: abandoned, memory keeps 0x11 at 0x20.
        req[0] = 1'b1; we[0] = 1'b1; addr[7:0] = 8'h20; wdata[7:0] = 8'h77;
        tick();
        check("midreset in access", {31'd0, busy}, 1);
        #2;
        req[0] = 1'b0; we[0] = 1'b0;
        do_reset();
        access(0, 1'b0, 8'h20, 8'h00, rd);
        check("midreset write dropped", {24'd0, rd}, 32'h11);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
